keypad_controller: RTL and testbench

KEYPAD_CONTROLLER -- requirements
Module: keypad_controller

---
 rtl/keypad_controller.sv | 191 +++++++++++++++++++
 tb/tb_keypad_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_controller.sv
// keypad_controller
//   Takes confirmed key presses from a matrix scanner, decodes the row/column
//   code into a hex key value, keeps a two-deep key history and time-
//   multiplexes that history onto a two-digit display. Also generates the
//   scanner step pulse.
//
//   Key path (FSM): IDLE -> DECODE -> COMMIT -> LOCKOUT -> IDLE.
//   The press is sampled on edge 1 (IDLE->DECODE), decoded on edge 2
//   (DECODE->COMMIT), and the history plus new_key update on edge 3
//   (COMMIT->LOCKOUT).
//
// Ports
//   clk          system clock, rising edge only
//   reset        asynchronous, active-low reset
//   key_valid    one-cycle strobe: scanner has a confirmed press
//   rows[3:0]    scanner row drive, one-hot high (rows[3] = row1)
//   cols[3:0]    debounced columns, active-low (cols[3] = col1)
//   scan_tick    one-cycle scanner step pulse every SCAN_DIV cycles
//   digit_new    most recent key value
//   digit_old    previous key value
//   seg_sel      display slot: 0 = digit_new, 1 = digit_old
//   anode[1:0]   active-low digit enables (2'b10 slot 0, 2'b01 slot 1)
//   shown_digit  value for the currently selected slot
//   new_key      one-cycle pulse when the history updates
//   err          sticky: an invalid row/col code was sampled
//   fsm_state    current FSM state (IDLE=0, DECODE=1, COMMIT=2, LOCKOUT=3)
//
// Handshake: key_valid is a strobe with no ready. It is accepted only on an
// edge where the FSM is in IDLE; in every other state it is dropped.
module keypad_controller #(
  parameter int SCAN_DIV    = 2500,
  parameter int MUX_DIV     = 5000,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] rows,
  input  logic [3:0] cols,
  output logic       scan_tick,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       seg_sel,
  output logic [1:0] anode,
  output logic [3:0] shown_digit,
  output logic       new_key,
  output logic       err,
  output logic [1:0] fsm_state
);

  localparam int SCW = $clog2(SCAN_DIV + 1);
  localparam int MCW = $clog2(MUX_DIV + 1);
  localparam int LCW = $clog2(LOCKOUT_CYC + 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [MCW-1:0] MUX_LAST  = MCW'(MUX_DIV - 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCKOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DECODE  = 2'd1,
    S_COMMIT  = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t         state, state_next;
  logic [SCW-1:0] scan_cnt;
  logic [MCW-1:0] mux_cnt;
  logic [LCW-1:0] lock_cnt;
  logic [3:0]     row_q, col_q;
  logic [3:0]     dec_q;
  logic [1:0]     r_idx, c_idx;
  logic [3:0]     key_val;
  logic           code_ok;

  // Free-running dividers, independent of the key path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      mux_cnt  <= '0;
      seg_sel  <= 1'b0;
    end else begin
      scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
      if (mux_cnt == MUX_LAST) begin
        mux_cnt <= '0;
        seg_sel <= ~seg_sel;
      end else begin
        mux_cnt <= mux_cnt + 1'b1;
      end
    end
  end

  assign scan_tick   = (scan_cnt == SCAN_LAST);
  assign anode       = seg_sel ? 2'b01 : 2'b10;
  assign shown_digit = seg_sel ? digit_old : digit_new;

  // A code is usable only with exactly one row driven and exactly one
  // column pulled low; anything else is a ghost/multi-key artefact.
  assign code_ok = $onehot(row_q) && $onehot(~col_q);

  always_comb begin
    r_idx = 2'd3;
    case (row_q)
      4'b1000: r_idx = 2'd0;
      4'b0100: r_idx = 2'd1;
      4'b0010: r_idx = 2'd2;
      default: r_idx = 2'd3;
    endcase
    c_idx = 2'd3;
    case (col_q)
      4'b0111: c_idx = 2'd0;
      4'b1011: c_idx = 2'd1;
      4'b1101: c_idx = 2'd2;
      default: c_idx = 2'd3;
    endcase
  end

  always_comb begin
    key_val = 4'h0;
    case ({r_idx, c_idx})
      4'b00_00: key_val = 4'h1;
      4'b00_01: key_val = 4'h2;
      4'b00_10: key_val = 4'h3;
      4'b00_11: key_val = 4'hA;
      4'b01_00: key_val = 4'h4;
      4'b01_01: key_val = 4'h5;
      4'b01_10: key_val = 4'h6;
      4'b01_11: key_val = 4'hB;
      4'b10_00: key_val = 4'h7;
      4'b10_01: key_val = 4'h8;
      4'b10_10: key_val = 4'h9;
      4'b10_11: key_val = 4'hC;
      4'b11_00: key_val = 4'hE;
      4'b11_01: key_val = 4'h0;
      4'b11_10: key_val = 4'hF;
      4'b11_11: key_val = 4'hD;
      default:  key_val = 4'h0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; unknown encodings fall back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (key_valid) state_next = S_DECODE;
      S_DECODE:  state_next = code_ok ? S_COMMIT : S_IDLE;
      S_COMMIT:  state_next = S_LOCKOUT;
      S_LOCKOUT: if (lock_cnt == LOCK_LAST) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  assign fsm_state = state;

  // Key datapath: capture, decode, history shift, lockout timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q     <= 4'h0;
      col_q     <= 4'hF;
      dec_q     <= 4'h0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
      new_key   <= 1'b0;
      err       <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      new_key <= 1'b0;
      if (state == S_IDLE && key_valid) begin
        row_q <= rows;
        col_q <= cols;
      end
      if (state == S_DECODE) begin
        if (code_ok) dec_q <= key_val;
        else         err   <= 1'b1;
      end
      if (state == S_COMMIT) begin
        digit_old <= digit_new;
        digit_new <= dec_q;
        new_key   <= 1'b1;
      end
      if (state == S_LOCKOUT && lock_cnt != LOCK_LAST) lock_cnt <= lock_cnt + 1'b1;
      else                                             lock_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_keypad_controller.sv
// Testbench for keypad_controller (SCAN_DIV=4, MUX_DIV=6, LOCKOUT_CYC=16).
// A table of key codes is applied in a loop; valid presses push the expected
// {digit_old, digit_new} pair into exp_q and a negedge monitor pops it when
// new_key fires. The monitor also checks divider outputs and display muxing
// every cycle against a cycle-count model. Hand-written sequences cover
// lockout, dropped strobes and reset during COMMIT.
module tb_keypad_controller;

  localparam int SCAN_DIV    = 4;
  localparam int MUX_DIV     = 6;
  localparam int LOCKOUT_CYC = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] rows, cols;
  logic       scan_tick, seg_sel, new_key, err;
  logic [3:0] digit_new, digit_old, shown_digit;
  logic [1:0] anode, fsm_state;

  keypad_controller #(
    .SCAN_DIV(SCAN_DIV), .MUX_DIV(MUX_DIV), .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .rows(rows), .cols(cols),
    .scan_tick(scan_tick), .digit_new(digit_new), .digit_old(digit_old),
    .seg_sel(seg_sel), .anode(anode), .shown_digit(shown_digit),
    .new_key(new_key), .err(err), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset-relative cycle count ----------------
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic mon_en = 1'b0;
  logic [3:0] m_new = 4'h0, m_old = 4'h0, drv_last = 4'h0;
  logic m_err = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (new_key) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_new_key", 1, 0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("hist_new", digit_new, e[3:0]);
          chk("hist_old", digit_old, e[7:4]);
          m_new = e[3:0];
          m_old = e[7:4];
        end
      end
      chk("scan_tick", scan_tick, (cyc % SCAN_DIV) == SCAN_DIV - 1);
      chk("seg_sel", seg_sel, (cyc / MUX_DIV) % 2);
      chk("anode", anode, ((cyc / MUX_DIV) % 2) ? 2'b01 : 2'b10);
      chk("shown_digit", shown_digit, ((cyc / MUX_DIV) % 2) ? m_old : m_new);
      chk("digit_new_hold", digit_new, m_new);
      chk("digit_old_hold", digit_old, m_old);
      chk("err_flag", err, m_err);
    end
  end

  // ---------------- driver tasks ----------------
  // Valid press. hold = cycles key_valid stays high (extra ones land in
  // DECODE/COMMIT and must be dropped); late = lockout cycle (1..15) at which
  // a second strobe is injected, 0 for none.
  task automatic press(input logic [3:0] r, input logic [3:0] c,
                       input logic [3:0] v, input int hold, input int late);
    @(negedge clk);
    rows = r; cols = c; key_valid = 1'b1;
    exp_q.push_back({drv_last, v});
    drv_last = v;
    @(negedge clk);
    if (hold <= 1) key_valid = 1'b0;
    chk("lat_edge1", new_key, 0);
    @(negedge clk);
    if (hold <= 2) key_valid = 1'b0;
    chk("lat_edge2", new_key, 0);
    chk("in_commit", fsm_state, 2);
    @(negedge clk);
    key_valid = 1'b0;
    chk("lat_edge3", new_key, 1);
    for (int k = 1; k <= LOCKOUT_CYC - 1; k++) begin
      @(negedge clk);
      key_valid = 1'b0;
      if (k == late) begin
        rows = 4'b0100; cols = 4'b1101;
        key_valid = 1'b1;
      end
    end
    chk("lockout_last", fsm_state, 3);
    @(negedge clk);
    key_valid = 1'b0;
    chk("lockout_exit", fsm_state, 0);
  endtask

  task automatic press_bad(input logic [3:0] r, input logic [3:0] c);
    @(negedge clk);
    rows = r; cols = c; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("bad_in_decode", fsm_state, 1);
    @(posedge clk);
    m_err = 1'b1;
    @(negedge clk);
    chk("bad_err", err, 1);
    chk("bad_back_idle", fsm_state, 0);
    chk("bad_no_new_key", new_key, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_digit_new"}, digit_new, 0);
    chk({tag, "_digit_old"}, digit_old, 0);
    chk({tag, "_new_key"}, new_key, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_scan_tick"}, scan_tick, 0);
    chk({tag, "_seg_sel"}, seg_sel, 0);
    chk({tag, "_anode"}, anode, 2'b10);
    chk({tag, "_shown"}, shown_digit, 0);
    chk({tag, "_state"}, fsm_state, 0);
  endtask

  // Press that gets reset while in COMMIT: no history update may survive.
  task automatic reset_in_commit(input logic [3:0] r, input logic [3:0] c);
    @(negedge clk);
    rows = r; cols = c; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_commit", fsm_state, 2);
    #2;
    mon_en = 1'b0;
    reset = 1'b0;
    m_new = 4'h0; m_old = 4'h0; m_err = 1'b0; drv_last = 4'h0;
    #1;
    check_reset_vals("rst_async");
    @(negedge clk);
    check_reset_vals("rst_held");
    reset = 1'b1;
    @(negedge clk);
    chk("rst_release_state", fsm_state, 0);
    chk("rst_release_new_key", new_key, 0);
    mon_en = 1'b1;
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [3:0] r;
    logic [3:0] c;
    logic       ok;
    logic [3:0] val;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{4'b1000, 4'b1011, 1'b1, 4'h2};
    vecs[1]  = '{4'b0001, 4'b0111, 1'b1, 4'hE};
    vecs[2]  = '{4'b1100, 4'b1011, 1'b0, 4'h0};  // two rows
    vecs[3]  = '{4'b1000, 4'b1110, 1'b1, 4'hA};
    vecs[4]  = '{4'b0100, 4'b1110, 1'b1, 4'hB};
    vecs[5]  = '{4'b0010, 4'b1101, 1'b1, 4'h9};
    vecs[6]  = '{4'b0001, 4'b1110, 1'b1, 4'hD};
    vecs[7]  = '{4'b0001, 4'b1011, 1'b1, 4'h0};
    vecs[8]  = '{4'b0010, 4'b1011, 1'b1, 4'h8};
    vecs[9]  = '{4'b0010, 4'b1011, 1'b1, 4'h8};  // same key twice
    vecs[10] = '{4'b1000, 4'b1001, 1'b0, 4'h0};  // two columns low
    vecs[11] = '{4'b0000, 4'b1011, 1'b0, 4'h0};  // no row
    vecs[12] = '{4'b0100, 4'b0111, 1'b1, 4'h4};
    vecs[13] = '{4'b0010, 4'b0111, 1'b1, 4'h7};

    reset = 1'b0; key_valid = 1'b0; rows = 4'h0; cols = 4'hF;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;
    #1 mon_en = 1'b1;

    // Idle run: divider pattern checked by the monitor.
    repeat (14) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].ok) press(vecs[i].r, vecs[i].c, vecs[i].val, 1, 0);
      else            press_bad(vecs[i].r, vecs[i].c);
    end

    press(4'b1000, 4'b0111, 4'h1, 1, 5);   // strobe 5 cycles into lockout
    press(4'b0100, 4'b1011, 4'h5, 1, 15);  // strobe in the last lockout cycle
    press(4'b0010, 4'b1110, 4'hC, 3, 0);   // strobe held through DECODE/COMMIT
    repeat (3) @(negedge clk);

    reset_in_commit(4'b0001, 4'b1101);
    repeat (5) @(negedge clk);
    press(4'b1000, 4'b1101, 4'h3, 1, 0);   // history restarts from 0
    repeat (4) @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
